// File: rtl/dmem_if.sv
// Request/response bus between the CPU memory port and the data-memory responder.
// The CPU side uses the master modport, the responder uses the slave modport.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with programmable wait states, byte-lane stores and
// sign/zero-extending loads; flags illegal, misaligned and out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        busy_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   word_idx;
  logic [1:0]    lane;
  logic [AW-1:0] mem_idx;
  logic          f3_ok;
  logic          align_ok;
  logic          range_ok;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic          mem_we;

  assign word_idx = addr_q[31:2];
  assign lane     = addr_q[1:0];
  assign mem_idx  = word_idx[AW-1:0];

  // Fault decode on the latched request.
  always_comb begin
    f3_ok = 1'b0;
    case (f3_q)
      3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
      3'd4, 3'd5:       f3_ok = !we_q;
      default:          f3_ok = 1'b0;
    endcase
    align_ok = 1'b1;
    if (f3_q[1:0] == 2'd1) begin
      align_ok = !lane[0];
    end else if (f3_q[1:0] == 2'd2) begin
      align_ok = (lane == 2'd0);
    end
    range_ok = ({2'b00, word_idx} < DEPTH_WORDS);
    acc_err  = !(f3_ok && align_ok && range_ok);
  end

  // Replicating the store data lets the byte enables alone pick the lanes.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'd0;
    case (f3_q[1:0])
      2'd0: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  assign rd_word = mem[mem_idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'd0;
    case (f3_q)
      3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_data = {24'd0, rd_byte};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_data = {16'd0, rd_half};
      3'd2:    load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // An asynchronous reset drops state out of StExec before the edge, so no write occurs.
  assign mem_we = (state_q == StExec) && we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            cnt_q       <= 4'(LATENCY);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (LATENCY > 0) ? StWait : StExec;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StExec;
          end
        end
        StExec: begin
          rdata_q      <= (acc_err || we_q) ? 32'd0 : load_data;
          err_q        <= acc_err;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;

  localparam int LAT     = 2;
  localparam int DEPTH   = 1024;
  localparam int EXP_LAT = LAT + 2;
  localparam int MWORDS  = 64;

  logic clk;
  logic rst;
  logic busy;
  int   n_tests;
  int   n_fail;

  logic [31:0] mem_m [MWORDS];

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    logic legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    size = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    if ((a % size) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    int unsigned sh;
    w  = mem_m[int'(a >> 2)];
    sh = 8 * (a % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> sh) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> sh) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int unsigned sh;
    int idx;
    idx  = int'(a >> 2);
    sh   = 8 * (a % 4);
    mask = (f3 == 3'd0) ? 32'hFF : ((f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF);
    mask = mask << sh;
    mem_m[idx] = (mem_m[idx] & ~mask) | ((d << sh) & mask);
  endtask

  // Drives one request, scrambles req_* after acceptance, returns the response and
  // the number of falling edges from the accept edge to the first resp_valid (-1 on timeout).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 50);
    if (!bus.resp_valid) lat = -1;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  // Runs a transaction and checks latency, error flag and data against the model.
  task automatic test_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        er;
    logic        exp_er;
    int          lat;
    exp_er = exp_err(we, f3, addr);
    exp_rd = (exp_er || we) ? 32'd0 : exp_load(f3, addr);
    run_txn(we, f3, addr, wdata, hold, rd, er, lat);
    if (!exp_er && we) model_store(f3, addr, wdata);
    n_tests++;
    if (lat !== EXP_LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, EXP_LAT);
    end
    n_tests++;
    if (er !== exp_er) begin
      n_fail++;
      $display("FAIL %s err: got %b want %b (addr %h f3 %0d)", name, er, exp_er, addr, f3);
    end
    n_tests++;
    if (rd !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h (addr %h f3 %0d)", name, rd, exp_rd, addr, f3);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.req_ready, bus.resp_valid, busy, bus.resp_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy/err %b want 1000",
               {bus.req_ready, bus.resp_valid, busy, bus.resp_err});
    end
    n_tests++;
    if (bus.resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_preload;
    for (int i = 0; i < MWORDS; i++) test_access("preload", 1'b1, 3'd2, 32'(i * 4), $urandom, 0);
  endtask

  task automatic test_word;
    test_access("sw_deadbeef", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
    test_access("lw_deadbeef", 1'b0, 3'd2, 32'h10, 32'h0, 0);
  endtask

  task automatic test_byte;
    test_access("sb_13", 1'b1, 3'd0, 32'h13, 32'h1234_5680, 1);
    test_access("lb_13", 1'b0, 3'd0, 32'h13, 32'h0, 0);
    test_access("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 0);
    test_access("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 0);
    n_tests++;
    if (mem_m[4] !== 32'h80AD_BEEF) begin
      n_fail++;
      $display("FAIL model_byte: got %h want 80adbeef", mem_m[4]);
    end
  endtask

  task automatic test_half;
    test_access("sh_22", 1'b1, 3'd1, 32'h22, 32'hABCD_8001, 0);
    test_access("lh_22", 1'b0, 3'd1, 32'h22, 32'h0, 0);
    test_access("lhu_22", 1'b0, 3'd5, 32'h22, 32'h0, 2);
    test_access("lw_20", 1'b0, 3'd2, 32'h20, 32'h0, 0);
  endtask

  task automatic test_errors;
    test_access("err_lw_11", 1'b0, 3'd2, 32'h11, 32'h0, 0);
    test_access("err_sh_21", 1'b1, 3'd1, 32'h21, 32'hFFFF_FFFF, 0);
    test_access("err_sw_11", 1'b1, 3'd2, 32'h11, 32'hFFFF_FFFF, 0);
    test_access("err_range", 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 0);
    test_access("err_srange", 1'b1, 3'd2, 32'(DEPTH * 4), 32'h5555_5555, 0);
    test_access("err_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 0);
    test_access("err_sbu", 1'b1, 3'd4, 32'h10, 32'h0, 0);
    test_access("after_err_10", 1'b0, 3'd2, 32'h10, 32'h0, 0);
    test_access("after_err_20", 1'b0, 3'd2, 32'h20, 32'h0, 0);
  endtask

  task automatic test_stall;
    logic [31:0] exp_rd;
    int n;
    exp_rd = exp_load(3'd2, 32'h10);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    bus.req_addr = 32'h20;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 50);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL stall_hold: got vld %b rdy %b rdata %h want 1 0 %h",
                 bus.resp_valid, bus.req_ready, bus.resp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.req_ready, bus.resp_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL stall_release: got rdy/vld/busy %b want 100",
               {bus.req_ready, bus.resp_valid, busy});
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.req_ready, bus.resp_valid, busy, bus.resp_err} !== 4'b1000
        || bus.resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy/vld/busy/err %b rdata %h want 1000 0",
               {bus.req_ready, bus.resp_valid, busy, bus.resp_err}, bus.resp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_noresp: got resp_valid %b want 0", seen);
    end
    test_access("reset_mid_lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 0);
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      else addr = $urandom_range(0, MWORDS * 4 - 1);
      test_access("random", we, f3, addr, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_preload();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
